// File: rtl/convolution_mac.sv
// rtl/convolution_mac.sv - signed saturating multiply-accumulate PE (optional o_sat via CONVOLUTION_MAC_SATFLAG_EN)
module convolution_mac #(
  parameter int I_X    = 8,
  parameter int I_W    = 8,
  parameter int I_PSUM = 16,
  parameter int O_SAT  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic signed [I_X-1:0]    i_x,
  input  logic signed [I_W-1:0]    i_w,
  input  logic signed [I_PSUM-1:0] i_psum,
  output logic signed [O_SAT-1:0]  o_psum
`ifdef CONVOLUTION_MAC_SATFLAG_EN
  ,
  output logic                     o_sat
`endif
);

  localparam int P_W = I_X + I_W;
  localparam int M_A = (O_SAT > P_W) ? O_SAT : P_W;
  localparam int M_B = (M_A > I_PSUM) ? M_A : I_PSUM;
  // Two guard bits: adding three in-range operands can never overflow.
  localparam int S_W = M_B + 2;

  localparam logic signed [S_W-1:0] SAT_MAX = {{(S_W-O_SAT+1){1'b0}}, {(O_SAT-1){1'b1}}};
  localparam logic signed [S_W-1:0] SAT_MIN = {{(S_W-O_SAT+1){1'b1}}, {(O_SAT-1){1'b0}}};

  logic signed [P_W-1:0]    x_ext, w_ext, prod;
  logic signed [I_PSUM-1:0] ps_r;
  logic signed [O_SAT-1:0]  acc, acc_next;
  logic signed [S_W-1:0]    acc_ext, prod_ext, ps_ext, sum;

  // Operand extension to full product width so the multiply keeps every bit.
  always_comb begin
    x_ext = {{I_W{i_x[I_X-1]}}, i_x};
    w_ext = {{I_X{i_w[I_W-1]}}, i_w};
  end

  // Stage 1: register the full-width product and the incoming partial sum.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prod <= '0;
      ps_r <= '0;
    end else begin
      prod <= x_ext * w_ext;
      ps_r <= i_psum;
    end
  end

  // Wide sum and clamp to the signed output range.
  always_comb begin
    acc_ext  = {{(S_W-O_SAT){acc[O_SAT-1]}}, acc};
    prod_ext = {{(S_W-P_W){prod[P_W-1]}}, prod};
    ps_ext   = {{(S_W-I_PSUM){ps_r[I_PSUM-1]}}, ps_r};
    sum      = acc_ext + prod_ext + ps_ext;
    acc_next = sum[O_SAT-1:0];
    if (sum > SAT_MAX) begin
      acc_next = SAT_MAX[O_SAT-1:0];
    end else if (sum < SAT_MIN) begin
      acc_next = SAT_MIN[O_SAT-1:0];
    end
  end

  // Stage 2: accumulator register, which is also the output.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next;
    end
  end

  assign o_psum = acc;

`ifdef CONVOLUTION_MAC_SATFLAG_EN
  logic clamp;
  assign clamp = (sum > SAT_MAX) || (sum < SAT_MIN);

  // Flag cycles where the accumulator update was clamped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sat <= 1'b0;
    end else begin
      o_sat <= clamp;
    end
  end
`endif

endmodule

// File: tb/tb_convolution_mac.sv
// tb/tb_convolution_mac.sv - self-checking bench for convolution_mac
module tb_convolution_mac;

  typedef struct {
    int x;
    int w;
    int p;
    int ev;
    bit es;
  } vec_t;

  typedef struct {
    int v;
    bit s;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [7:0]  x, w;
  logic signed [15:0] psum, out;
`ifdef CONVOLUTION_MAC_SATFLAG_EN
  logic               sat;
`endif

  int   pass_cnt = 0;
  int   total    = 0;
  int   ref_acc  = 0;
  exp_t q[$];
  vec_t tab[10];

  convolution_mac #(.I_X(8), .I_W(8), .I_PSUM(16), .O_SAT(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_x   (x),
    .i_w   (w),
    .i_psum(psum),
    .o_psum(out)
`ifdef CONVOLUTION_MAC_SATFLAG_EN
    ,
    .o_sat (sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act == expv) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  task automatic cmp_next();
    exp_t e;
    e = q.pop_front();
    check("o_psum", int'(out), e.v);
`ifdef CONVOLUTION_MAC_SATFLAG_EN
    check("o_sat", int'(sat), int'(e.s));
`endif
  endtask

  // Drive one input set, push its expected accumulator, compare the one due now.
  task automatic drive(input int xi, input int wi, input int pi, input int ev, input bit es);
    exp_t e;
    x = 8'(xi);
    w = 8'(wi);
    psum = 16'(pi);
    e.v = ev;
    e.s = es;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() >= 2) cmp_next();
  endtask

  // Reference accumulator: plain integer sum with clamping.
  task automatic model_step(input int xi, input int wi, input int pi);
    longint s;
    bit     c;
    s = longint'(ref_acc) + longint'(xi * wi) + longint'(pi);
    c = 1'b0;
    if (s > 32767) begin s = 32767; c = 1'b1; end
    else if (s < -32768) begin s = -32768; c = 1'b1; end
    ref_acc = int'(s);
    drive(xi, wi, pi, ref_acc, c);
  endtask

  task automatic flush();
    x = '0;
    w = '0;
    psum = '0;
    @(posedge clk);
    #1;
    while (q.size() > 0) cmp_next();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_async", int'(out), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    ref_acc = 0;
  endtask

  initial begin
    // Hand-computed sequence from zero: psum-only, max positive product, clamp, decay.
    tab[0] = '{0, 0, 300, 300, 1'b0};
    tab[1] = '{0, 0, 300, 600, 1'b0};
    tab[2] = '{0, 0, 300, 900, 1'b0};
    tab[3] = '{0, 0, -1000, -100, 1'b0};
    tab[4] = '{-128, -128, 0, 16284, 1'b0};
    tab[5] = '{-128, -128, 0, 32668, 1'b0};
    tab[6] = '{-128, -128, 0, 32767, 1'b1};
    tab[7] = '{-1, 1, 0, 32766, 1'b0};
    tab[8] = '{-128, 127, 0, 16510, 1'b0};
    tab[9] = '{5, -7, 100, 16575, 1'b0};

    // Reset held with live inputs: nothing accumulates.
    rst = 1'b1;
    x = 8'sd10;
    w = 8'sd5;
    psum = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", int'(out), 0);
    end
    rst = 1'b0;

    // Ramp 50 per cycle into positive saturation, then hold.
    for (int i = 0; i < 700; i++) model_step(10, 5, 0);
    check("ramp_sat_ref", ref_acc, 32767);
    // Leave saturation without wrap.
    for (int i = 0; i < 5; i++) model_step(-1, 1, 0);
    flush();

    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(tab[i].x, tab[i].w, tab[i].p, tab[i].ev, tab[i].es);
      ref_acc = tab[i].ev;
    end
    flush();

    // Negative saturation.
    do_reset();
    drive(-128, 127, 0, -16256, 1'b0);
    drive(-128, 127, 0, -32512, 1'b0);
    drive(-128, 127, 0, -32768, 1'b1);
    drive(-128, 127, 0, -32768, 1'b1);
    flush();

    // Asynchronous reset between edges, then clean restart.
    do_reset();
    for (int i = 0; i < 3; i++) model_step(7, 9, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_async", int'(out), 0);
    q.delete();
    ref_acc = 0;
    @(posedge clk);
    #1;
    check("rst_mid_hold", int'(out), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) model_step(3, 4, 0);
    flush();
    check("restart_final", int'(out), 36);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
